// File: rtl/seq_divider_pkg.sv
// Shared ALU divider package: width, FSM states, divide-by-zero constant.
// Signed support is enabled by defining SEQ_DIVIDER_SIGNED_EN.
package seq_divider_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_e;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/seq_divider_if.sv
// Operand and result valid/ready handshakes of the sequential divider.
// The f_signed field only matters when SEQ_DIVIDER_SIGNED_EN is defined.
interface seq_divider_if #(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             f_signed;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid,
    output a,
    output b,
    output f_signed,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  quotient,
    input  remainder,
    input  div_by_zero
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  f_signed,
    input  out_ready,
    output in_ready,
    output out_valid,
    output quotient,
    output remainder,
    output div_by_zero
  );

endinterface

// File: rtl/seq_divider_sub.sv
// Ripple-borrow subtractor: diff = a - b, borrow set when a < b.
// Used as the trial subtractor of the divider iteration.
module ripple_borrow_subtractor #(
  parameter int N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  always_comb begin
    logic bw;
    bw   = 1'b0;
    diff = '0;
    for (int i = 0; i < N; i++) begin
      diff[i] = a[i] ^ b[i] ^ bw;
      bw = (~a[i] & b[i])
         | (~(a[i] ^ b[i]) & bw);
    end
    borrow = bw;
  end

endmodule

// File: rtl/seq_divider.sv
// Restoring sequential divider, one quotient bit per cycle.
// Define SEQ_DIVIDER_SIGNED_EN for signed division via f_signed.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic      clk,
  input logic      reset_n,
  seq_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  div_state_e state_q;
  div_state_e state_d;

  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] q_out;
  logic [WIDTH-1:0] r_out;
  logic             dbz_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  logic accept;
  logic zero_start;
  logic start;
  logic busy;
  logic last;

  assign accept     = bus.in_valid
                   && (state_q == DIV_IDLE);
  assign zero_start = accept && (bus.b == '0);
  assign start      = accept && (bus.b != '0);
  assign busy       = (state_q == DIV_BUSY);
  assign last       = busy
                   && (cnt_q == CW'(WIDTH-1));

  assign shifted = {rem_q, quo_q[WIDTH-1]};

  ripple_borrow_subtractor #(
    .N(WIDTH+1)
  ) u_sub (
    .a     (shifted),
    .b     ({1'b0, div_q}),
    .diff  (diff),
    .borrow(borrow)
  );

  assign rem_step = borrow ? shifted[WIDTH-1:0]
                           : diff[WIDTH-1:0];
  assign quo_step = {quo_q[WIDTH-2:0], ~borrow};

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic sa;
  logic sb;
  logic neg_q_q;
  logic neg_r_q;

  assign sa    = bus.f_signed & bus.a[WIDTH-1];
  assign sb    = bus.f_signed & bus.b[WIDTH-1];
  assign a_mag = sa ? -bus.a : bus.a;
  assign b_mag = sb ? -bus.b : bus.b;

  // Quotient sign follows the operand signs, remainder follows the dividend.
  assign quo_fix = neg_q_q ? -quo_step : quo_step;
  assign rem_fix = neg_r_q ? -rem_step : rem_step;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else if (start) begin
      neg_q_q <= sa ^ sb;
      neg_r_q <= sa;
    end
  end
`else
  logic unused_f_signed;

  assign unused_f_signed = bus.f_signed;
  assign a_mag   = bus.a;
  assign b_mag   = bus.b;
  assign quo_fix = quo_step;
  assign rem_fix = rem_step;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= DIV_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DIV_IDLE: begin
        if (zero_start) begin
          state_d = DIV_DONE;
        end else if (start) begin
          state_d = DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        if (last) begin
          state_d = DIV_DONE;
        end
      end
      DIV_DONE: begin
        if (bus.out_ready) begin
          state_d = DIV_IDLE;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      div_q <= b_mag;
      rem_q <= '0;
      quo_q <= a_mag;
      cnt_q <= '0;
    end else if (busy) begin
      rem_q <= rem_step;
      quo_q <= quo_step;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_out <= '0;
      r_out <= '0;
      dbz_q <= 1'b0;
    end else if (zero_start) begin
      q_out <= WIDTH'(DIV_ZERO_Q);
      r_out <= bus.a;
      dbz_q <= 1'b1;
    end else if (last) begin
      q_out <= quo_fix;
      r_out <= rem_fix;
      dbz_q <= 1'b0;
    end
  end

  assign bus.in_ready    = (state_q == DIV_IDLE);
  assign bus.out_valid   = (state_q == DIV_DONE);
  assign bus.quotient    = q_out;
  assign bus.remainder   = r_out;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider.
// Signed vectors run only when SEQ_DIVIDER_SIGNED_EN is defined.
module tb_seq_divider;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_bad;
  int   cyc;

  seq_divider_if #(.WIDTH(32)) dif ();

  seq_divider #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
               tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        s
  );
    int n;
    n = 0;
    while (!dif.in_ready && n < 50) begin
      tick();
      n++;
    end
    dif.a        = a;
    dif.b        = b;
    dif.f_signed = s;
    dif.in_valid = 1'b1;
    tick();
    dif.in_valid = 1'b0;
  endtask

  task automatic wait_valid(
    input  string tag,
    output int    c
  );
    c = 1;
    while (!dif.out_valid && c < 100) begin
      tick();
      c++;
    end
    check({tag, "_valid"}, 32'(dif.out_valid), 32'd1);
  endtask

  task automatic consume();
    dif.out_ready = 1'b1;
    tick();
    dif.out_ready = 1'b0;
  endtask

  task automatic run_div(
    input string       tag,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        s,
    input logic [31:0] eq,
    input logic [31:0] er,
    input logic        ez
  );
    int c;
    start_op(a, b, s);
    wait_valid(tag, c);
    check({tag, "_q"}, dif.quotient, eq);
    check({tag, "_r"}, dif.remainder, er);
    check({tag, "_dbz"}, 32'(dif.div_by_zero), 32'(ez));
    consume();
    check({tag, "_rdy"}, 32'(dif.in_ready), 32'd1);
  endtask

  initial begin
    n_cmp         = 0;
    n_bad         = 0;
    reset_n       = 1'b0;
    dif.in_valid  = 1'b0;
    dif.a         = '0;
    dif.b         = '0;
    dif.f_signed  = 1'b0;
    dif.out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 32'(dif.in_ready), 32'd1);
    check("rst_out_valid", 32'(dif.out_valid), 32'd0);
    check("rst_q", dif.quotient, 32'd0);
    check("rst_r", dif.remainder, 32'd0);
    check("rst_dbz", 32'(dif.div_by_zero), 32'd0);
    reset_n = 1'b1;
    tick();

    start_op(32'd100, 32'd7, 1'b0);
    wait_valid("u100_7", cyc);
    check("u100_7_cyc", 32'(cyc), 32'd33);
    check("u100_7_q", dif.quotient, 32'd14);
    check("u100_7_r", dif.remainder, 32'd2);
    check("u100_7_dbz", 32'(dif.div_by_zero), 32'd0);
    consume();
    check("u100_7_rdy", 32'(dif.in_ready), 32'd1);

    run_div("umax_1", 32'hFFFF_FFFF, 32'd1, 1'b0,
            32'hFFFF_FFFF, 32'd0, 1'b0);
    check("hold_q_idle", dif.quotient, 32'hFFFF_FFFF);
    run_div("u5_9", 32'd5, 32'd9, 1'b0,
            32'd0, 32'd5, 1'b0);

    start_op(32'd1234, 32'd0, 1'b0);
    wait_valid("dz", cyc);
    check("dz_cyc", 32'(cyc), 32'd1);
    check("dz_q", dif.quotient, 32'hFFFF_FFFF);
    check("dz_r", dif.remainder, 32'd1234);
    check("dz_dbz", 32'(dif.div_by_zero), 32'd1);
    consume();
    check("dz_rdy", 32'(dif.in_ready), 32'd1);

`ifdef SEQ_DIVIDER_SIGNED_EN
    run_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1,
            32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run_div("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF,
            1'b1, 32'h8000_0000, 32'd0, 1'b0);
    run_div("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1,
            32'hFFFF_FFFD, 32'd1, 1'b0);
`else
    run_div("nosgn", 32'hFFFF_FFF9, 32'd2, 1'b1,
            32'h7FFF_FFFC, 32'd1, 1'b0);
`endif

    start_op(32'd100, 32'd7, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bsy_in_ready", 32'(dif.in_ready), 32'd0);
      dif.a        = 32'd9;
      dif.b        = 32'd0;
      dif.in_valid = 1'b1;
      tick();
      dif.in_valid = 1'b0;
    end
    wait_valid("bp", cyc);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", 32'(dif.out_valid), 32'd1);
      check("bp_in_ready", 32'(dif.in_ready), 32'd0);
      check("bp_q", dif.quotient, 32'd14);
      check("bp_r", dif.remainder, 32'd2);
    end
    check("bp_dbz", 32'(dif.div_by_zero), 32'd0);
    consume();
    check("bp_rdy", 32'(dif.in_ready), 32'd1);
    check("bp_done", 32'(dif.out_valid), 32'd0);

    start_op(32'd100, 32'd7, 1'b0);
    for (int i = 1; i < 15; i++) begin
      tick();
    end
    check("pre_rst_busy", 32'(dif.in_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    check("mr_in_ready", 32'(dif.in_ready), 32'd1);
    check("mr_out_valid", 32'(dif.out_valid), 32'd0);
    check("mr_q", dif.quotient, 32'd0);
    check("mr_r", dif.remainder, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    start_op(32'd100, 32'd7, 1'b0);
    wait_valid("post", cyc);
    check("post_cyc", 32'(cyc), 32'd33);
    check("post_q", dif.quotient, 32'd14);
    check("post_r", dif.remainder, 32'd2);
    consume();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
